// File: rtl/aes_host_seq.sv
// aes_host_seq: host-side sequencer that drives an AES wrapper through config, key load,
// block load, status polling and result readback for one operation per start request.
module aes_host_seq #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         rekey,
  input  logic         encdec,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [127:0] block_in,
  output logic [3:0]   control,
  output logic [15:0]  write_data,
  input  logic [7:0]   data_in,
  output logic [127:0] result,
  output logic         busy,
  output logic         done,
  output logic         error
);
  localparam int CW = $clog2(TIMEOUT + 4);
  typedef enum logic [3:0] {IDLE, CFG, KEY, INIT, WAIT_RDY, BLK, NEXT, WAIT_VLD, READ, DONE, ERR} state_t;
  state_t         state;
  logic [255:0]   key_r;
  logic [127:0]   blk_r, shadow;
  logic           rekey_r, key_ok;
  logic [3:0]     idx, bidx;
  logic [CW-1:0]  cnt;
  logic [15:0]    key_word, blk_word;
  logic           poll_ok, timed_out;
  always_comb begin
    key_word  = key_r[{~idx, 4'b0} +: 16];
    blk_word  = blk_r[{~idx[2:0], 4'b0} +: 16];
    bidx      = control == 4'd0 ? 4'hf : idx - 4'd1;
    poll_ok   = cnt >= CW'(2) && (state == WAIT_RDY ? data_in[0] : data_in[1]);
    timed_out = cnt >= CW'(TIMEOUT);
  end
  assign busy  = state != IDLE;
  assign done  = state == DONE || state == ERR;
  assign error = state == ERR;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      control    <= 4'd0;
      write_data <= 16'd0;
      result     <= 128'd0;
      shadow     <= 128'd0;
      key_r      <= 256'd0;
      blk_r      <= 128'd0;
      rekey_r    <= 1'b0;
      key_ok     <= 1'b0;
      idx        <= 4'd0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          key_r      <= key;
          blk_r      <= block_in;
          rekey_r    <= rekey;
          idx        <= 4'd0;
          control    <= 4'd4;
          write_data <= {14'd0, keylen, encdec};
          state      <= CFG;
        end
        CFG: begin
          state      <= (rekey_r || !key_ok) ? KEY : BLK;
          control    <= (rekey_r || !key_ok) ? 4'd2 : 4'd1;
          write_data <= (rekey_r || !key_ok) ? key_word : blk_word;
          idx        <= 4'd1;
        end
        KEY: if (idx == 4'd0) begin
          state      <= INIT;
          control    <= 4'd5;
          write_data <= 16'h0001;
        end else begin
          write_data <= key_word;
          idx        <= idx + 4'd1;
        end
        INIT: begin
          state      <= WAIT_RDY;
          control    <= 4'd3;
          write_data <= 16'd0;
          cnt        <= '0;
        end
        WAIT_RDY: if (poll_ok) begin
          key_ok     <= 1'b1;
          state      <= BLK;
          control    <= 4'd1;
          write_data <= blk_word;
          idx        <= 4'd1;
        end else if (timed_out) begin
          key_ok     <= 1'b0;
          state      <= ERR;
          control    <= 4'd0;
        end else cnt <= cnt + 1'b1;
        BLK: if (idx == 4'd8) begin
          state      <= NEXT;
          control    <= 4'd5;
          write_data <= 16'h0002;
          idx        <= 4'd0;
        end else begin
          write_data <= blk_word;
          idx        <= idx + 4'd1;
        end
        NEXT: begin
          state      <= WAIT_VLD;
          control    <= 4'd3;
          write_data <= 16'd0;
          cnt        <= '0;
        end
        WAIT_VLD: if (poll_ok) begin
          state      <= READ;
          control    <= 4'd6;
          idx        <= 4'd0;
        end else if (timed_out) begin
          key_ok     <= 1'b0;
          state      <= ERR;
          control    <= 4'd0;
        end else cnt <= cnt + 1'b1;
        // each byte arrives one cycle after its RESULT_OUT; the trailing NOP cycle collects byte 15
        READ: begin
          if (control == 4'd0 || idx != 4'd0) shadow[{~bidx, 3'b0} +: 8] <= data_in;
          if (control == 4'd0) state <= DONE;
          else begin
            control <= idx == 4'd15 ? 4'd0 : 4'd6;
            idx     <= idx + 4'd1;
          end
        end
        DONE: begin
          result <= shadow;
          state  <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_host_seq.sv
// tb_aes_host_seq: random and directed operations against a cycle-list reference model,
// with a wrapper model answering STATUS polls and RESULT_OUT reads.
module tb_aes_host_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic rekey = 1'b0, encdec = 1'b0, keylen = 1'b0;
  logic [255:0] key = '0;
  logic [127:0] block_in = '0;
  logic [1:0] start = '0;
  logic [1:0][7:0] din = '0;
  logic [1:0][3:0] ctl;
  logic [1:0][15:0] wd;
  logic [1:0][127:0] res;
  logic [1:0] bsy, dn, er;
  aes_host_seq u_dut (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .rekey(rekey), .encdec(encdec),
    .keylen(keylen), .key(key), .block_in(block_in), .control(ctl[0]), .write_data(wd[0]),
    .data_in(din[0]), .result(res[0]), .busy(bsy[0]), .done(dn[0]), .error(er[0])
  );
  aes_host_seq #(.TIMEOUT(7)) u_to (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .rekey(rekey), .encdec(encdec),
    .keylen(keylen), .key(key), .block_in(block_in), .control(ctl[1]), .write_data(wd[1]),
    .data_in(din[1]), .result(res[1]), .busy(bsy[1]), .done(dn[1]), .error(er[1])
  );
  int total = 0, bad = 0;
  int poll[2] = '{0, 0}, rc[2] = '{0, 0}, rdy_at[2] = '{0, 0}, vld_at[2] = '{0, 0};
  bit frc[2] = '{0, 0};
  bit kok[2] = '{0, 0};
  logic [3:0] prev[2] = '{4'd0, 4'd0};
  logic [127:0] rbytes[2] = '{128'd0, 128'd0};
  logic [127:0] last_res[2] = '{128'd0, 128'd0};
  // wrapper model: status bits after N polls, result bytes one cycle after each RESULT_OUT
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      poll[u] = (ctl[u] == 4'd3) ? poll[u] + 1 : 0;
      din[u] = {6'd0, vld_at[u] != 0 && poll[u] >= vld_at[u], frc[u] || (rdy_at[u] != 0 && poll[u] >= rdy_at[u])};
      if (prev[u] == 4'd6) begin
        din[u] = rbytes[u][127-8*rc[u] -: 8];
        rc[u]++;
      end else rc[u] = 0;
      prev[u] = ctl[u];
    end
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [22:0] obs(input int u);
    return {dn[u], er[u], bsy[u], ctl[u], wd[u]};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic run_op(input int u, input bit rk, input bit kl, input bit ed, input logic [255:0] k,
                        input logic [127:0] b, input int wr, input int wv, input logic [127:0] r,
                        input bit fr, input int poke, input bit abrt);
    logic [19:0] q[$];
    int to = (u == 0) ? 1023 : 7;
    bit kload = rk || !kok[u];
    bit err = 0;
    int wre = fr ? 3 : wr;
    int ab;
    q.push_back({4'd4, 14'd0, kl, ed});
    if (kload) begin
      for (int i = 0; i < 16; i++) q.push_back({4'd2, k[255-16*i -: 16]});
      q.push_back({4'd5, 16'd1});
      for (int i = 0; i < ((wre == 0) ? to + 1 : wre); i++) q.push_back({4'd3, 16'd0});
      err = (wre == 0);
    end
    if (!err) begin
      for (int i = 0; i < 8; i++) q.push_back({4'd1, b[127-16*i -: 16]});
      q.push_back({4'd5, 16'd2});
      for (int i = 0; i < ((wv == 0) ? to + 1 : wv); i++) q.push_back({4'd3, 16'd0});
      err = (wv == 0);
      if (!err) begin
        for (int i = 0; i < 16; i++) q.push_back({4'd6, 16'd0});
        q.push_back({4'd0, 16'd0});
      end
    end
    ab = abrt ? q.size() - 13 : -1;
    rdy_at[u] = wr; vld_at[u] = wv; frc[u] = fr; rbytes[u] = r;
    @(negedge clk);
    rekey = rk; keylen = kl; encdec = ed; key = k; block_in = b; start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      chk("step", 256'(obs(u)), {233'd0, 3'b001, q[j]});
      if (j == ab) begin
        #2 reset_n = 1'b0;
        #1 chk("rst_now", 256'({bsy[u], dn[u], ctl[u]}), 256'd0);
        chk("rst_result", 256'(res[u]), 256'd0);
        kok = '{0, 0};
        last_res = '{128'd0, 128'd0};
        frc[u] = 0;
        repeat (2) begin
          @(negedge clk);
          chk("rst_hold", 256'(obs(u)), 256'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst", 256'(obs(u)), 256'd0);
        return;
      end
      start[u] = (j == poke);
      @(negedge clk);
    end
    start[u] = 1'b0;
    chk(err ? "err_cycle" : "done_cycle", 256'(obs(u)), {233'd0, 1'b1, err, 1'b1, 20'd0});
    if (kload && wre != 0) kok[u] = 1;
    if (err) kok[u] = 0;
    if (!err) last_res[u] = r;
    @(negedge clk);
    chk("idle", 256'(obs(u)), 256'd0);
    chk("result", 256'(res[u]), 256'(last_res[u]));
    frc[u] = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    logic [255:0] fk;
    logic [127:0] fb, fr;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_out", 256'(obs(u)), 256'd0);
      chk("reset_res", 256'(res[u]), 256'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_op(1, 1, 0, 1, {rnd128(), rnd128()}, rnd128(), 3, 4, rnd128(), 0, -1, 0);
    run_op(1, 1, 1, 0, {rnd128(), rnd128()}, rnd128(), 0, 3, rnd128(), 0, -1, 0);
    run_op(1, 0, 0, 1, {rnd128(), rnd128()}, rnd128(), 3, 3, rnd128(), 0, -1, 0);
    fk = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    fb = 128'h00112233445566778899aabbccddeeff;
    fr = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    run_op(0, 1, 0, 1, fk, fb, 5, 12, fr, 0, -1, 0);
    run_op(0, 0, 0, 1, fk, fb, 5, 12, fr, 0, -1, 0);
    run_op(0, 1, 1, 1, {rnd128(), rnd128()}, rnd128(), 9, 4, rnd128(), 1, -1, 0);
    for (int n = 0; n < 6; n++)
      run_op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {rnd128(), rnd128()}, rnd128(), $urandom_range(3, 8), $urandom_range(3, 8), rnd128(),
             0, (n % 2 == 1) ? int'($urandom_range(0, 20)) : -1, 0);
    run_op(0, 0, 0, 1, {rnd128(), rnd128()}, rnd128(), 4, 5, rnd128(), 0, -1, 1);
    run_op(0, 0, 1, 0, {rnd128(), rnd128()}, rnd128(), 3, 6, rnd128(), 0, -1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
